sbox_layer_sequencer: RTL and testbench

- Initiator for the clock-gated masked Skinny S-box (first-order, two shares) and its gated-clock/Synch handshake.
- Takes a 64-bit two-share state, feeds it nibble by nibble into the S-box, and holds the S-box inputs stable for the whole gadget pipeline.
- Re-arms the S-box clock-gating controller for each nibble, waits for Synch, and captures the S-box output shares.
- Returns the substituted 64-bit state as two shares. Sits between the round-state register and the S-box in the serial SubCells datapath.

---
 rtl/sbox_layer_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_sbox_layer_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_layer_sequencer.sv
// Serial SubCells sequencer: streams a two-share state nibble by nibble through a
// clock-gated masked S-box, re-arming it per nibble and reassembling the output shares.
module sbox_layer_sequencer #(
  parameter int NIBBLES = 16,
  parameter int LATENCY = 9,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NIBBLES-1:0] in_s0,
  input  logic [4*NIBBLES-1:0] in_s1,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*NIBBLES-1:0] out_s0,
  output logic [4*NIBBLES-1:0] out_s1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sbox_rst,
  output logic [3:0]           sbox_SI_s0,
  output logic [3:0]           sbox_SI_s1,
  input  logic                 sbox_Synch,
  input  logic [3:0]           sbox_SO_s0,
  input  logic [3:0]           sbox_SO_s1,
  output logic                 busy,
  output logic                 err
);

  // A timeout shorter than the gadget period would fire on every nibble; clamp it.
  localparam int TMO_EFF = (TIMEOUT > LATENCY) ? TIMEOUT : (LATENCY + 1);
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int CNT_W   = $clog2(TMO_EFF + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TMO_EFF);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_EFF - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               state_r;
  state_t               next_state_s;
  logic [IDX_W-1:0]     idx_r;
  logic [IDX_W-1:0]     load_idx_s;
  logic [CNT_W-1:0]     wait_cnt_r;
  logic [4*NIBBLES-1:0] buf_s0_r;
  logic [4*NIBBLES-1:0] buf_s1_r;
  logic [3:0]           si_s0_r;
  logic [3:0]           si_s1_r;
  logic [3:0]           si_s0_s;
  logic [3:0]           si_s1_s;
  logic                 in_ready_r;
  logic                 in_ready_s;
  logic                 busy_r;
  logic                 busy_s;
  logic                 sbox_rst_r;
  logic                 sbox_rst_s;
  logic                 out_valid_r;
  logic                 out_valid_s;
  logic                 err_r;
  logic                 timeout_s;

  assign timeout_s  = (state_r == S_WAIT) && !sbox_Synch && (wait_cnt_r >= TMO_LAST);
  assign load_idx_s = (state_r == S_CAPTURE) ? (idx_r + IDX_W'(1)) : {IDX_W{1'b0}};

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          next_state_s = S_LOAD;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        next_state_s = S_WAIT;
      end
      S_WAIT: begin
        if (sbox_Synch) begin
          next_state_s = S_CAPTURE;
        end else if (timeout_s) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_CAPTURE: begin
        if (idx_r == LAST_IDX) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_LOAD;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_DONE;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered outputs, derived from the next state
  always_comb begin
    in_ready_s  = (next_state_s == S_IDLE);
    busy_s      = (next_state_s != S_IDLE) && (next_state_s != S_DONE);
    // The S-box keeps running through CAPTURE so its output shares stay valid.
    sbox_rst_s  = (next_state_s != S_WAIT) && (next_state_s != S_CAPTURE);
    out_valid_s = (next_state_s == S_DONE);
    si_s0_s     = si_s0_r;
    si_s1_s     = si_s1_r;
    if (next_state_s == S_LOAD) begin
      if (state_r == S_IDLE) begin
        si_s0_s = in_s0[3:0];
        si_s1_s = in_s1[3:0];
      end else begin
        si_s0_s = buf_s0_r[{load_idx_s, 2'b00} +: 4];
        si_s1_s = buf_s1_r[{load_idx_s, 2'b00} +: 4];
      end
    end else begin
      si_s0_s = si_s0_r;
      si_s1_s = si_s1_r;
    end
  end

  // State register and registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      sbox_rst_r  <= 1'b1;
      out_valid_r <= 1'b0;
      si_s0_r     <= 4'd0;
      si_s1_r     <= 4'd0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= in_ready_s;
      busy_r      <= busy_s;
      sbox_rst_r  <= sbox_rst_s;
      out_valid_r <= out_valid_s;
      si_s0_r     <= si_s0_s;
      si_s1_r     <= si_s1_s;
    end
  end

  // Datapath: share buffers, nibble index, Synch wait counter and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_s0_r   <= {(4*NIBBLES){1'b0}};
      buf_s1_r   <= {(4*NIBBLES){1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      wait_cnt_r <= {CNT_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            buf_s0_r <= in_s0;
            buf_s1_r <= in_s1;
            idx_r    <= {IDX_W{1'b0}};
            err_r    <= 1'b0;
          end
        end
        S_LOAD: begin
          wait_cnt_r <= {CNT_W{1'b0}};
        end
        S_WAIT: begin
          if (wait_cnt_r != TMO_MAX) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
          if (timeout_s) begin
            err_r <= 1'b1;
          end
        end
        S_CAPTURE: begin
          buf_s0_r[{idx_r, 2'b00} +: 4] <= sbox_SO_s0;
          buf_s1_r[{idx_r, 2'b00} +: 4] <= sbox_SO_s1;
          if (idx_r != LAST_IDX) begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign sbox_rst   = sbox_rst_r;
  assign out_valid  = out_valid_r;
  assign out_s0     = buf_s0_r;
  assign out_s1     = buf_s1_r;
  assign sbox_SI_s0 = si_s0_r;
  assign sbox_SI_s1 = si_s1_r;
  assign err        = err_r;

endmodule

// File: tb/tb_sbox_layer_sequencer.sv
// Scoreboard bench for sbox_layer_sequencer with a behavioural masked Skinny S-box
// that re-shares its outputs with a fresh random mask per nibble.
module tb_sbox_layer_sequencer;

  localparam int NIBBLES = 16;
  localparam int LATENCY = 9;
  localparam int TIMEOUT = 16;
  localparam int LAT_EXP = 177;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_s0 = 64'd0;
  logic [63:0] in_s1 = 64'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_s0;
  logic [63:0] out_s1;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        sbox_rst;
  logic [3:0]  sbox_SI_s0;
  logic [3:0]  sbox_SI_s1;
  logic        sbox_Synch;
  logic [3:0]  sbox_SO_s0;
  logic [3:0]  sbox_SO_s1;
  logic        busy;
  logic        err;

  logic [3:0]  mask = 4'd0;
  int          mcnt = 0;
  int          nib_seen = 0;
  int          ncyc = 0;
  bit          force_synch = 1'b0;
  bit          supp = 1'b0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [63:0] res;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  sbox_layer_sequencer #(.NIBBLES(NIBBLES), .LATENCY(LATENCY), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_s0(in_s0), .in_s1(in_s1), .in_valid(in_valid),
    .in_ready(in_ready), .out_s0(out_s0), .out_s1(out_s1), .out_valid(out_valid),
    .out_ready(out_ready), .sbox_rst(sbox_rst), .sbox_SI_s0(sbox_SI_s0),
    .sbox_SI_s1(sbox_SI_s1), .sbox_Synch(sbox_Synch), .sbox_SO_s0(sbox_SO_s0),
    .sbox_SO_s1(sbox_SO_s1), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Skinny-64 4-bit S-box; nibble i of the table holds S(i)
  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] t;
    t = 64'hF7E4D583B2A1096C;
    return t[{x, 2'b00} +: 4];
  endfunction

  assign sbox_SO_s0 = sb(sbox_SI_s0 ^ sbox_SI_s1) ^ mask;
  assign sbox_SO_s1 = mask;
  assign sbox_Synch = (force_synch && sbox_rst) ||
                      (!sbox_rst && (mcnt == LATENCY - 1) && !(supp && (nib_seen == 6)));

  // Gadget model: period counter restarts while held in reset; new mask per nibble
  always @(posedge clk) begin
    if (sbox_rst) begin
      mcnt <= 0;
      mask <= 4'($urandom);
    end else if (mcnt < 31) begin
      mcnt <= mcnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    chk(name, {63'd0, act}, {63'd0, expv});
  endtask

  // Monitor: S-box input stability, nibble tracking and result scoreboard
  initial begin
    exp_t        e;
    bit          ov_q;
    logic [7:0]  si_lat;
    ov_q   = 1'b0;
    si_lat = 8'd0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (in_valid && in_ready) begin
        nib_seen = 0;
      end else if (busy && sbox_rst) begin
        nib_seen++;
      end
      if (sbox_rst) begin
        si_lat = {sbox_SI_s0, sbox_SI_s1};
      end else begin
        chk("si_stable", {56'd0, sbox_SI_s0, sbox_SI_s1}, {56'd0, si_lat});
      end
      if (out_valid && !ov_q) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", out_s0 ^ out_s1, e.res);
          chk("latency", 64'(ncyc - e.acc), 64'(LAT_EXP));
          chk1("err_at_done", err, 1'b0);
        end
      end
      ov_q = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [63:0] s0, input logic [63:0] s1,
                       input logic [63:0] res, input bit push);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 400) begin
      tick();
      n++;
    end
    chk1("in_ready_wait", in_ready, 1'b1);
    in_s0    = s0;
    in_s1    = s1;
    in_valid = 1'b1;
    if (push) begin
      e.res = res;
      e.acc = ncyc + 1;
      exp_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
    chk1("err_clear_on_accept", err, 1'b0);
    chk1("busy_after_accept", busy, 1'b1);
    chk1("in_ready_low_busy", in_ready, 1'b0);
  endtask

  task automatic finish_run();
    int n;
    n = 0;
    while (!in_ready && n < 400) begin
      tick();
      n++;
    end
    chk1("run_complete", in_ready, 1'b1);
  endtask

  task automatic run_vec(input logic [63:0] s0, input logic [63:0] s1, input logic [63:0] res);
    start(s0, s1, res, 1'b1);
    finish_run();
  endtask

  logic [63:0] plain_t[5];
  logic [63:0] subst_t[5];

  initial begin
    logic [63:0] r;
    logic [63:0] o0;
    logic [63:0] o1;
    int          n;
    int          w;

    plain_t[0] = 64'h0123456789ABCDEF;  subst_t[0] = 64'hC6901A2B385D4E7F;
    plain_t[1] = 64'hF0F0F0F00F0F0F0F;  subst_t[1] = 64'hFCFCFCFCCFCFCFCF;
    plain_t[2] = 64'hCFBCAFFEDBEFE11C;  subst_t[2] = 64'h4FD45FF7ED7F7664;
    plain_t[3] = 64'h0000000000000000;  subst_t[3] = 64'hCCCCCCCCCCCCCCCC;
    plain_t[4] = 64'hFEDCBA9876543210;  subst_t[4] = 64'hF7E4D583B2A1096C;

    repeat (3) tick();
    chk1("rst_sbox_rst", sbox_rst, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();
    chk1("reset_in_ready", in_ready, 1'b1);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_sbox_rst", sbox_rst, 1'b1);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_err", err, 1'b0);
    chk("reset_out_s0", out_s0, 64'd0);
    chk("reset_out_s1", out_s1, 64'd0);
    chk("reset_si", {56'd0, sbox_SI_s0, sbox_SI_s1}, 64'd0);

    // Unmasked-equivalent run
    run_vec(64'h0123456789ABCDEF, 64'd0, 64'hC6901A2B385D4E7F);

    // Random share splits of the directed plaintexts
    for (int k = 0; k < 3; k++) begin
      for (int v = 0; v < 5; v++) begin
        r = {32'($urandom), 32'($urandom)};
        run_vec(plain_t[v] ^ r, r, subst_t[v]);
      end
    end

    // Spurious Synch whenever the S-box is held in reset (IDLE, LOAD, DONE)
    force_synch = 1'b1;
    repeat (3) tick();
    chk1("spurious_idle_busy", busy, 1'b0);
    chk1("spurious_idle_ov", out_valid, 1'b0);
    r = {32'($urandom), 32'($urandom)};
    run_vec(plain_t[2] ^ r, r, subst_t[2]);
    force_synch = 1'b0;

    // Backpressure
    out_ready = 1'b0;
    r = {32'($urandom), 32'($urandom)};
    start(plain_t[4] ^ r, r, subst_t[4], 1'b1);
    n = 0;
    while (!out_valid && n < 400) begin
      tick();
      n++;
    end
    chk1("bp_out_valid", out_valid, 1'b1);
    o0 = out_s0;
    o1 = out_s1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("bp_hold_s0", out_s0, o0);
      chk("bp_hold_s1", out_s1, o1);
      chk1("bp_hold_valid", out_valid, 1'b1);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    chk1("bp_release_valid", out_valid, 1'b0);
    chk1("bp_release_idle", in_ready, 1'b1);

    // Synch withheld on nibble 5
    supp = 1'b1;
    start(plain_t[1], 64'd0, 64'd0, 1'b0);
    n = 0;
    while (!(nib_seen == 6 && !sbox_rst) && n < 200) begin
      tick();
      n++;
    end
    w = 0;
    n = 0;
    while (!err && n < 40) begin
      if (!sbox_rst) w++;
      tick();
      n++;
    end
    chk("timeout_wait_cycles", 64'(w), 64'd16);
    chk1("timeout_err", err, 1'b1);
    chk1("timeout_idle", in_ready, 1'b1);
    chk1("timeout_busy", busy, 1'b0);
    chk1("timeout_out_valid", out_valid, 1'b0);
    supp = 1'b0;
    repeat (4) tick();
    chk1("timeout_err_sticky", err, 1'b1);
    chk1("timeout_no_valid", out_valid, 1'b0);
    run_vec(plain_t[0], 64'd0, subst_t[0]);

    // Reset during WAIT of nibble 7
    start(plain_t[2], 64'd0, subst_t[2], 1'b1);
    n = 0;
    while (!(nib_seen == 8 && !sbox_rst) && n < 200) begin
      tick();
      n++;
    end
    chk1("mid_rst_in_wait", sbox_rst, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_sbox_rst", sbox_rst, 1'b1);
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_s0", out_s0, 64'd0);
    chk("mid_rst_out_s1", out_s1, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    r = {32'($urandom), 32'($urandom)};
    run_vec(plain_t[0] ^ r, r, subst_t[0]);

    repeat (3) tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
